// File: rtl/bit_framer_pkg.sv
// -----------------------------------------------------------------------------
// bit_framer_pkg
//   Shared types and constants for the bit_framer slice: frame FSM state,
//   tstrb codes for sync/payload words and the gearbox widths.
// -----------------------------------------------------------------------------
package bit_framer_pkg;

  localparam int IN_W   = 32;  // input word width
  localparam int OUT_W  = 40;  // payload word width
  localparam int BUF_W  = 72;  // gearbox buffer: OUT_W + IN_W worst case
  localparam int FILL_W = 7;   // fill count range 0..72

  localparam logic [4:0] SYNC_TSTRB    = 5'h01;
  localparam logic [4:0] PAYLOAD_TSTRB = 5'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD
  } state_e;

endpackage : bit_framer_pkg

// File: rtl/gearbox_32to40.sv
// -----------------------------------------------------------------------------
// gearbox_32to40
//   Re-packs a 32-bit LSB-first bit stream into 40-bit words. Valid bits sit
//   in r_buf[r_fill-1:0], oldest bit at bit 0; every bit at or above r_fill
//   is kept zero so a new word can be OR-ed in at offset r_fill.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      synchronous clear (same effect as reset)
//   i_push       accept i_data this cycle (caller gates with o_ready)
//   i_data       32 input bits, bit 0 earliest
//   o_ready      room for one more input word (fill <= 40)
//   i_pop        consume o_data this cycle (caller gates with o_valid)
//   o_valid      a full 40-bit word is buffered (fill >= 40)
//   o_data       oldest 40 buffered bits
// -----------------------------------------------------------------------------
module gearbox_32to40
  import bit_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_ready,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data
);

  logic [BUF_W-1:0]  r_buf;
  logic [BUF_W-1:0]  w_shifted;
  logic [BUF_W-1:0]  w_buf_next;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_base;
  logic [FILL_W-1:0] w_fill_next;

  // Accept only while fill <= 40, so fill + 32 never exceeds the 72-bit buffer.
  assign o_ready = (r_fill <= FILL_W'(OUT_W));
  assign o_valid = (r_fill >= FILL_W'(OUT_W));
  assign o_data  = r_buf[OUT_W-1:0];

  // Pop first, then insert the new word on top of whatever remains. Push and
  // pop together only happen at fill == 40, leaving fill = 32.
  // NOTE: every variable assigned in always_comb gets a default on entry so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_shifted   = r_buf;
    w_base      = r_fill;
    if (i_pop) begin
      w_shifted = r_buf >> OUT_W;
      w_base    = r_fill - FILL_W'(OUT_W);
    end
    w_buf_next  = w_shifted;
    w_fill_next = w_base;
    if (i_push) begin
      w_buf_next  = w_shifted | (BUF_W'(i_data) << w_base);
      w_fill_next = w_base + FILL_W'(IN_W);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from the values present before the clock edge. The buffer
  // itself is reset (not just fill) because the OR-insert relies on the bits
  // above fill being zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;
    end
  end

endmodule : gearbox_32to40

// File: rtl/bit_framer.sv
// -----------------------------------------------------------------------------
// bit_framer
//   Frames a continuous 32-bit AXI-Stream bit stream into 40-bit payload words,
//   emitting one sync word ahead of every PAYLOAD_WORDS payload words. Leftover
//   gearbox bits carry across frames; nothing is padded or flushed.
//
// Parameters
//   SYNC_WORD      32-bit sync pattern, sent as {8'h00, SYNC_WORD}
//   PAYLOAD_WORDS  payload words per frame, 1..255
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   reset_mod  synchronous active-high clear, same effect as rst
//   s_valid / s_ready / s_data            32-bit input stream, bit 0 earliest
//   m_valid / m_ready / m_data            40-bit output stream, bit 0 earliest
//   m_tstrb    5'h01 sync word, 5'h00 payload word
//   m_tlast    last payload word of a frame
// -----------------------------------------------------------------------------
module bit_framer
  import bit_framer_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD     = 32'hA5A5_F00F,
  parameter int          PAYLOAD_WORDS = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_mod,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [4:0]       m_tstrb,
  output logic             m_tlast
);

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_wcnt;
  logic [7:0]       w_wcnt_next;
  logic             w_gb_ready;
  logic             w_gb_valid;
  logic [OUT_W-1:0] w_gb_data;
  logic             w_push;
  logic             w_pop;
  logic             w_last;

  // All handshake qualifiers come from registered state (fill, state, wcnt);
  // s_valid and m_ready only gate the transfer, never the valid/ready flags.
  assign s_ready = w_gb_ready && (r_state != ST_IDLE);
  assign w_push  = s_valid && s_ready;
  assign w_last  = (r_state == ST_PAYLOAD) && (r_wcnt == 8'(PAYLOAD_WORDS - 1));
  assign w_pop   = (r_state == ST_PAYLOAD) && w_gb_valid && m_ready;

  gearbox_32to40 u_gearbox (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (reset_mod),
    .i_push  (w_push),
    .i_data  (s_data),
    .o_ready (w_gb_ready),
    .i_pop   (w_pop),
    .o_valid (w_gb_valid),
    .o_data  (w_gb_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
    end else if (reset_mod) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // Defaults present the sync word, which is also what IDLE and reset show.
  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    m_valid      = 1'b0;
    m_data       = {8'h00, SYNC_WORD};
    m_tstrb      = SYNC_TSTRB;
    m_tlast      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_SYNC;
      end
      ST_SYNC: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_state_next = ST_PAYLOAD;
          w_wcnt_next  = '0;
        end
      end
      ST_PAYLOAD: begin
        m_valid = w_gb_valid;
        m_data  = w_gb_data;
        m_tstrb = PAYLOAD_TSTRB;
        m_tlast = w_last;
        if (w_pop) begin
          if (w_last) begin
            w_state_next = ST_SYNC;
          end else begin
            w_wcnt_next = r_wcnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule : bit_framer

// File: tb/tb_bit_framer.sv
// -----------------------------------------------------------------------------
// tb_bit_framer
//   Directed bench for bit_framer. Inputs are driven and outputs sampled on
//   the falling edge; a bit-level scoreboard and a frame-position counter
//   give the expected value of every output word.
// -----------------------------------------------------------------------------
module tb_bit_framer;

  localparam logic [31:0] SYNC = 32'hA5A5_F00F;
  localparam int          NW   = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mod;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [39:0] m_data;
  logic [4:0]  m_tstrb;
  logic        m_tlast;

  int errors = 0;
  int checks = 0;

  bit_framer #(.SYNC_WORD(SYNC), .PAYLOAD_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .reset_mod (reset_mod),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_tstrb   (m_tstrb),
    .m_tlast   (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source: 0 = explicit list only, 1 = constant DEADBEEF, 2 = random words.
  int          src_mode = 0;
  logic [31:0] src_q[$];
  bit          rnd_ready = 1'b0;

  // Scoreboard / model state.
  bit          bits_q[$];
  int          pos = 0;          // 0 = sync expected, k = payload word k
  bit          in_hs_q = 1'b0;   // word at src_q[0] will be taken at next edge
  bit          prev_stall = 1'b0;
  logic [39:0] hold_data;
  logic [4:0]  hold_strb;
  logic        hold_last;
  int          out_cnt = 0;
  int          sync_cnt = 0;
  int          tlast_cnt = 0;
  int          pay_cnt = 0;
  logic [39:0] pay_log[$];

  task automatic clear_model();
    bits_q.delete();
    pos        = 0;
    in_hs_q    = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, score handshakes
  // that will complete at the next rising edge.
  task automatic step(input bit clr = 1'b0);
    logic [39:0] exp;
    @(negedge clk);
    if (in_hs_q) void'(src_q.pop_front());
    if (src_mode == 1) while (src_q.size() < 2) src_q.push_back(32'hDEAD_BEEF);
    if (src_mode == 2) while (src_q.size() < 2) src_q.push_back($urandom);
    s_valid   = (src_q.size() > 0);
    s_data    = s_valid ? src_q[0] : 32'h0;
    m_ready   = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    reset_mod = clr;
    #1;
    if (!rst || reset_mod) begin
      clear_model();
      return;
    end
    in_hs_q = s_valid && s_ready;
    if (prev_stall) begin
      check("stall_valid", 40'(m_valid), 40'd1);
      check("stall_data", m_data, hold_data);
      check("stall_strb", 40'(m_tstrb), 40'(hold_strb));
      check("stall_last", 40'(m_tlast), 40'(hold_last));
    end
    prev_stall = m_valid && !m_ready;
    hold_data  = m_data;
    hold_strb  = m_tstrb;
    hold_last  = m_tlast;
    if (in_hs_q) for (int i = 0; i < 32; i++) bits_q.push_back(s_data[i]);
    if (m_valid && m_ready) begin
      out_cnt++;
      if (pos == 0) begin
        check("sync_data", m_data, {8'h00, SYNC});
        check("sync_strb", 40'(m_tstrb), 40'h01);
        check("sync_last", 40'(m_tlast), 40'd0);
        sync_cnt++;
        pos = 1;
      end else begin
        if (bits_q.size() < 40) begin
          check("sb_underflow", 40'(bits_q.size()), 40'd40);
        end else begin
          for (int i = 0; i < 40; i++) exp[i] = bits_q.pop_front();
          check("pay_data", m_data, exp);
        end
        check("pay_strb", 40'(m_tstrb), 40'h00);
        check("pay_last", 40'(m_tlast), 40'(pos == NW));
        pay_log.push_back(m_data);
        pay_cnt++;
        if (m_tlast) tlast_cnt++;
        pos = (pos == NW) ? 0 : pos + 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until payload word 7 of the current frame is on the bus.
  task automatic reach_word7();
    for (int i = 0; i < 300 && !(pos == 7 && m_valid); i++) step();
    check("reach_word7", 40'(pos == 7 && m_valid), 40'd1);
  endtask

  initial begin
    rst       = 1'b0;
    reset_mod = 1'b0;
    s_valid   = 1'b0;
    s_data    = 32'h0;
    m_ready   = 1'b1;

    // Reset values, then a single sync word and silence.
    #1;
    check("rst_m_valid", 40'(m_valid), 40'd0);
    check("rst_s_ready", 40'(s_ready), 40'd0);
    check("rst_m_tlast", 40'(m_tlast), 40'd0);
    check("rst_m_tstrb", 40'(m_tstrb), 40'h01);
    check("rst_m_data", m_data, {8'h00, SYNC});
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("idle_m_valid", 40'(m_valid), 40'd0);
    check("idle_s_ready", 40'(s_ready), 40'd0);
    step();
    check("sync_up_valid", 40'(m_valid), 40'd1);
    check("sync_up_ready", 40'(s_ready), 40'd1);
    run(20);
    check("idle_one_word", 40'(out_cnt), 40'd1);
    check("idle_quiet", 40'(m_valid), 40'd0);

    // First payload words from three directed inputs.
    step(1'b1);
    src_q.delete();
    pay_log.delete();
    src_q.push_back(32'h0000_0001);
    src_q.push_back(32'hFFFF_FF02);
    src_q.push_back(32'h0000_0003);
    run(20);
    check("first_pay_cnt", 40'(pay_log.size()), 40'd2);
    if (pay_log.size() >= 2) begin
      check("first_pay0", pay_log[0], 40'h02_0000_0001);
      check("first_pay1", pay_log[1], 40'h00_03FF_FFFF);
    end

    // Three full frames of continuous DEADBEEF, no backpressure.
    step(1'b1);
    src_q.delete();
    src_mode  = 1;
    sync_cnt  = 0;
    tlast_cnt = 0;
    for (int i = 0; i < 400 && tlast_cnt < 3; i++) step();
    run(2);
    check("frames_tlast", 40'(tlast_cnt), 40'd3);
    check("frames_sync", 40'(sync_cnt), 40'd4);

    // Random backpressure at ~30% ready against continuous random input.
    src_mode  = 2;
    rnd_ready = 1'b1;
    pay_cnt   = 0;
    run(600);
    rnd_ready = 1'b0;
    check("bp_progress", 40'(pay_cnt > 50), 40'd1);

    // Asynchronous reset during payload word 7.
    reach_word7();
    #2 rst = 1'b0;
    clear_model();
    #1;
    check("arst_drop_valid", 40'(m_valid), 40'd0);
    check("arst_drop_ready", 40'(s_ready), 40'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    pay_cnt = 0;
    step();
    check("arst_idle", 40'(m_valid), 40'd0);
    step();
    check("arst_sync", 40'(m_valid && m_tstrb == 5'h01), 40'd1);
    run(60);
    check("arst_payload", 40'(pay_cnt > 10), 40'd1);

    // Same sequence with the synchronous clear.
    reach_word7();
    step(1'b1);
    pay_cnt = 0;
    step();
    check("sclr_idle", 40'(m_valid), 40'd0);
    step();
    check("sclr_sync", 40'(m_valid && m_tstrb == 5'h01), 40'd1);
    run(60);
    check("sclr_payload", 40'(pay_cnt > 10), 40'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bit_framer
